// File: rtl/mem_arbiter_pkg.sv
// Shared types for the CPU/DMA memory arbiter: FSM state encoding,
// grant IDs and the WAIT down-counter width.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic GNT_CPU = 1'b0;
  localparam logic GNT_DMA = 1'b1;

  // holds MEM_LAT-1 for MEM_LAT in 1..4
  localparam int CNT_W = 3;

endpackage

// File: rtl/arb_grant_sel.sv
// Winner select between CPU and DMA requests.
// in: cpu_req, dma_req, last_grant  out: grant (GNT_CPU/GNT_DMA)
module arb_grant_sel
  import mem_arbiter_pkg::*;
(
  input  logic cpu_req,
  input  logic dma_req,
  input  logic last_grant,
  output logic grant
);

  // On a tie the side not served last wins; a constant last_grant
  // of GNT_DMA turns this into fixed CPU priority.
  always_comb begin
    grant = GNT_CPU;
    unique case (1'b1)
      (cpu_req && dma_req):
        grant = (last_grant == GNT_CPU) ? GNT_DMA : GNT_CPU;
      (dma_req && !cpu_req):
        grant = GNT_DMA;
      default:
        grant = GNT_CPU;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master (CPU, DMA) arbiter onto one single-port memory.
// Ports: clk, reset (async, active-low); cpu_* / dma_* request side
// (req, we, addr, wdata in; rdata, ack out; cpu_stall out);
// mem_* memory side (en, we, addr, wdata out; rdata in).
// Macro MEM_ARB_RR_EN: round-robin on ties; undefined: CPU priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  output logic          cpu_stall,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic             any_req;
  logic             gnt_sel;
  logic             gnt;
  logic             last_gnt;
  logic             lat_we;
  logic [AW-1:0]    lat_addr;
  logic [DW-1:0]    lat_wdata;
  logic [DW-1:0]    cpu_rd_q;
  logic [DW-1:0]    dma_rd_q;
  logic             rd_cap;

  assign any_req = cpu_req | dma_req;

  arb_grant_sel u_sel (
    .cpu_req    (cpu_req),
    .dma_req    (dma_req),
    .last_grant (last_gnt),
    .grant      (gnt_sel)
  );

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_gnt <= GNT_DMA;
    end else if (state == S_ISSUE) begin
      last_gnt <= gnt;
    end
  end
`else
  assign last_gnt = GNT_DMA;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (any_req) state_nx = S_ISSUE;
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT:  if (cnt == '0) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Inputs are sampled once; later changes are ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt       <= GNT_CPU;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (state == S_IDLE && any_req) begin
      gnt <= gnt_sel;
      if (gnt_sel == GNT_CPU) begin
        lat_we    <= cpu_we;
        lat_addr  <= cpu_addr;
        lat_wdata <= cpu_wdata;
      end else begin
        lat_we    <= dma_we;
        lat_addr  <= dma_addr;
        lat_wdata <= dma_wdata;
      end
    end
  end

  // WAIT lasts MEM_LAT cycles: loaded in ISSUE, exits at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (state == S_ISSUE) begin
      cnt <= CNT_W'(MEM_LAT - 1);
    end else if (state == S_WAIT && cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign rd_cap = (state == S_WAIT) && (cnt == '0) && !lat_we;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_rd_q <= '0;
      dma_rd_q <= '0;
    end else if (rd_cap) begin
      if (gnt == GNT_CPU) begin
        cpu_rd_q <= mem_rdata;
      end else begin
        dma_rd_q <= mem_rdata;
      end
    end
  end

  always_comb begin
    mem_en    = (state == S_ISSUE);
    mem_we    = (state == S_ISSUE) && lat_we;
    mem_addr  = lat_addr;
    mem_wdata = lat_wdata;
    cpu_ack   = (state == S_DONE) && (gnt == GNT_CPU);
    dma_ack   = (state == S_DONE) && (gnt == GNT_DMA);
    cpu_rdata = cpu_rd_q;
    dma_rdata = dma_rd_q;
    cpu_stall = cpu_req && !cpu_ack;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: MEM_LAT=1 instance with a memory
// model, plus a MEM_LAT=4 instance for the long-latency case.
module tb_mem_arbiter;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic        who;
    logic [31:0] cpu_d;
    logic [31:0] dma_d;
    int          ack_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 0, cpu_we = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0;
  logic        dma_req = 0, dma_we = 0;
  logic [31:0] dma_addr = 0, dma_wdata = 0;
  logic [31:0] cpu_rdata, dma_rdata;
  logic        cpu_ack, cpu_stall, dma_ack;
  logic        m_en, m_we;
  logic [31:0] m_addr, m_wdata, m_rdata;

  logic        c4_req = 0;
  logic [31:0] c4_addr = 0;
  logic [31:0] c4_rdata, d4_rdata;
  logic        c4_ack, c4_stall, d4_ack;
  logic        m4_en, m4_we;
  logic [31:0] m4_addr, m4_wdata, m4_rdata;

  logic [31:0] exp_c = 0;
  logic [31:0] exp_d = 0;

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter #(.DW(32), .AW(32), .MEM_LAT(1)) u0 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .mem_en(m_en), .mem_we(m_we), .mem_addr(m_addr),
    .mem_wdata(m_wdata), .mem_rdata(m_rdata)
  );

  mem_arbiter #(.DW(32), .AW(32), .MEM_LAT(4)) u4 (
    .clk(clk), .reset(reset),
    .cpu_req(c4_req), .cpu_we(1'b0),
    .cpu_addr(c4_addr), .cpu_wdata(32'h0),
    .cpu_rdata(c4_rdata), .cpu_ack(c4_ack), .cpu_stall(c4_stall),
    .dma_req(1'b0), .dma_we(1'b0),
    .dma_addr(32'h0), .dma_wdata(32'h0),
    .dma_rdata(d4_rdata), .dma_ack(d4_ack),
    .mem_en(m4_en), .mem_we(m4_we), .mem_addr(m4_addr),
    .mem_wdata(m4_wdata), .mem_rdata(m4_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory model: unwritten words read a fixed per-address pattern.
  logic [31:0] mem0[64];
  bit   [63:0] wv0;
  logic [31:0] rd0 = 32'h0BAD_0BAD;
  logic [31:0] p4[4];

  function automatic logic [31:0] init_val(input logic [31:0] a);
    if (a == 32'h10) return 32'h8C01_0004;
    return (a * 32'h0101_0101) ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] mrd(input logic [31:0] a);
    return wv0[a[7:2]] ? mem0[a[7:2]] : init_val(a);
  endfunction

  // Read data is only valid MEM_LAT cycles after mem_en.
  always @(posedge clk) begin
    rd0 <= 32'h0BAD_0BAD;
    if (m_en) begin
      if (m_we) begin
        mem0[m_addr[7:2]] <= m_wdata;
        wv0[m_addr[7:2]]  <= 1'b1;
      end else begin
        rd0 <= mrd(m_addr);
      end
    end
  end
  assign m_rdata = rd0;

  always @(posedge clk) begin
    p4[0] <= (m4_en && !m4_we) ? init_val(m4_addr) : 32'h0BAD_0BAD;
    for (int i = 1; i < 4; i++) p4[i] <= p4[i-1];
  end
  assign m4_rdata = p4[3];

  always @(negedge clk) begin : mon
    exp_t e;
    if (reset) begin
      chk("we_outside_issue", 64'(m_we & ~m_en), 64'(0));
      if (cpu_ack || dma_ack) begin
        chk("dual_ack", 64'(cpu_ack & dma_ack), 64'(0));
        if (sb.size() == 0) begin
          chk("unexpected_ack", 64'({cpu_ack, dma_ack}), 64'(0));
        end else begin
          e = sb.pop_front();
          chk("ack_who", 64'(dma_ack), 64'(e.who));
          chk("ack_cycle", 64'(cyc), 64'(e.ack_cyc));
          chk("cpu_rdata", 64'(cpu_rdata), 64'(e.cpu_d));
          chk("dma_rdata", 64'(dma_rdata), 64'(e.dma_d));
        end
      end
    end
  end

  task automatic push(input logic who, input int ack_cyc);
    exp_t e;
    e.who = who;
    e.cpu_d = exp_c;
    e.dma_d = exp_d;
    e.ack_cyc = ack_cyc;
    sb.push_back(e);
  endtask

  task automatic drain(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk("sb_drain_timeout", 64'(sb.size()), 64'(0));
      sb.delete();
    end
    #1;
    cpu_req = 1'b0;
    dma_req = 1'b0;
  endtask

  task automatic run_txn(input logic who, input logic we,
                         input logic [31:0] addr, input logic [31:0] wd);
    int t0;
    @(posedge clk);
    #1;
    if (who) begin
      dma_req = 1; dma_we = we; dma_addr = addr; dma_wdata = wd;
    end else begin
      cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    end
    t0 = cyc;
    if (!we) begin
      if (who) exp_d = mrd(addr);
      else exp_c = mrd(addr);
    end
    push(who, t0 + 3);
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      chk("mem_en", 64'(m_en), 64'(k == 1));
      chk("mem_we", 64'(m_we), 64'(k == 1 && we));
      if (k == 1) chk("mem_addr", 64'(m_addr), 64'(addr));
      if (k == 1 && we) chk("mem_wdata", 64'(m_wdata), 64'(wd));
      if (!who) chk("cpu_stall", 64'(cpu_stall), 64'(k < 3));
    end
    drain(8);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: no end of test by %0t", $time);
    $fatal(1);
  end

  initial begin : main
    int t0;
    int r;
    int nen;
    int got;
    #1 reset = 1'b0;
    cpu_req = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_en", 64'(m_en), 64'(0));
    chk("rst_mem_we", 64'(m_we), 64'(0));
    chk("rst_cpu_ack", 64'(cpu_ack), 64'(0));
    chk("rst_dma_ack", 64'(dma_ack), 64'(0));
    chk("rst_cpu_rdata", 64'(cpu_rdata), 64'(0));
    chk("rst_dma_rdata", 64'(dma_rdata), 64'(0));
    chk("rst_stall", 64'(cpu_stall), 64'(1));
    cpu_req = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;

    run_txn(1'b0, 1'b0, 32'h10, 32'h0);
    chk("cpu_read_word", 64'(cpu_rdata), 64'h8C01_0004);

    run_txn(1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF);
    chk("mem_written", 64'(mrd(32'h20)), 64'hDEAD_BEEF);
    chk("dma_rdata_kept", 64'(dma_rdata), 64'(0));
    run_txn(1'b0, 1'b0, 32'h20, 32'h0);
    chk("cpu_read_back", 64'(cpu_rdata), 64'hDEAD_BEEF);

    run_txn(1'b0, 1'b1, 32'h48, 32'h55AA_33CC);
    run_txn(1'b1, 1'b0, 32'h44, 32'h0);

    // Both requesters held across four transactions.
    @(posedge clk);
    #1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h04;
    dma_req = 1; dma_we = 0; dma_addr = 32'h08;
    t0 = cyc;
    for (int i = 0; i < 4; i++) begin
      if (RR && i[0]) begin
        exp_d = mrd(32'h08);
        push(1'b1, t0 + 3 + 4 * i);
      end else begin
        exp_c = mrd(32'h04);
        push(1'b0, t0 + 3 + 4 * i);
      end
    end
    drain(30);
    repeat (6) @(posedge clk);

    // Request withdrawn during WAIT still completes.
    @(posedge clk);
    #1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0C;
    t0 = cyc;
    exp_c = mrd(32'h0C);
    push(1'b0, t0 + 3);
    @(posedge clk);
    @(posedge clk);
    #1 cpu_req = 1'b0;
    drain(8);
    repeat (4) @(posedge clk);

    // Reset during WAIT aborts; CPU wins first afterwards.
    @(posedge clk);
    #1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h14;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    dma_req = 1; dma_we = 0; dma_addr = 32'h18;
    #1;
    chk("rst_wait_mem_en", 64'(m_en), 64'(0));
    chk("rst_wait_ack", 64'({cpu_ack, dma_ack}), 64'(0));
    exp_c = 0;
    exp_d = 0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_hold_ack", 64'({cpu_ack, dma_ack}), 64'(0));
      chk("rst_hold_rdata", 64'({cpu_rdata, dma_rdata}), 64'(0));
    end
    @(posedge clk);
    #1 reset = 1'b1;
    r = cyc;
    exp_c = mrd(32'h14);
    push(1'b0, r + 3);
    drain(8);
    repeat (4) @(posedge clk);

    // Reset during ISSUE of a write must not reach memory.
    @(posedge clk);
    #1;
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h40; cpu_wdata = 32'hFFFF_0000;
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rst_issue_mem_en", 64'(m_en), 64'(0));
    chk("rst_issue_mem_we", 64'(m_we), 64'(0));
    @(posedge clk);
    #1 cpu_req = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    exp_c = 0;
    exp_d = 0;
    repeat (3) @(posedge clk);
    chk("no_write_after_rst", 64'(wv0[16]), 64'(0));

    // MEM_LAT=4 instance.
    @(posedge clk);
    #1;
    c4_req = 1; c4_addr = 32'h2C;
    t0 = cyc;
    nen = 0;
    got = -1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (m4_en) nen++;
      if (c4_ack) begin
        got = cyc - t0;
        break;
      end
    end
    @(posedge clk);
    #1 c4_req = 1'b0;
    chk("lat4_ack_cycle", 64'(got), 64'(6));
    chk("lat4_mem_en_cycles", 64'(nen), 64'(1));
    chk("lat4_rdata", 64'(c4_rdata), 64'(init_val(32'h2C)));
    repeat (4) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DW, default 32: data width.
REQ-002 SHALL have parameter AW, default 32: address width.
REQ-003 SHALL have parameter MEM_LAT, default 1, legal range 1..4: memory read latency in cycles from mem_en.
REQ-004 SHALL have port clk  in  1: single clock; all state on rising edge.
REQ-005 SHALL have port reset  in  1: asynchronous, active-low reset.
REQ-006 SHALL have ports cpu_req in 1, cpu_we in 1, cpu_addr in AW, cpu_wdata in DW: processor access request (fetch/load/store).
REQ-007 SHALL have ports cpu_rdata out DW, cpu_ack out 1, cpu_stall out 1: processor response and stall to control unit.
REQ-008 SHALL have ports dma_req in 1, dma_we in 1, dma_addr in AW, dma_wdata in DW: loader/DMA request.
REQ-009 SHALL have ports dma_rdata out DW, dma_ack out 1: loader/DMA response.
REQ-010 SHALL have ports mem_en out 1, mem_we out 1, mem_addr out AW, mem_wdata out DW, mem_rdata in DW: single-port memory side.

Function
REQ-011 SHALL implement FSM IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
REQ-012 IDLE: on any req, SHALL select a winner, latch its we/addr/wdata, and go to ISSUE; otherwise stay.
REQ-013 ISSUE: SHALL drive mem_en=1 and latched mem_we/mem_addr/mem_wdata for exactly one cycle.
REQ-014 WAIT: SHALL last exactly MEM_LAT cycles via a down-counter; SHALL capture mem_rdata in the final WAIT cycle on reads only.
REQ-015 DONE: SHALL pulse the winner's ack for exactly one cycle with its rdata valid; then return to IDLE.
REQ-016 Latency: req high in IDLE cycle 0 -> ack in cycle MEM_LAT+2; identical for reads and writes.
REQ-017 Back-to-back: one IDLE cycle between transactions.
REQ-018 Outside ISSUE, mem_en and mem_we SHALL be 0.
REQ-019 cpu_rdata/dma_rdata SHALL hold their last captured read value; writes SHALL NOT update them.
REQ-020 cpu_stall SHALL equal cpu_req AND NOT cpu_ack (combinational).
REQ-021 A requester SHALL hold req and inputs stable until ack; the arbiter ignores input changes after latching.
REQ-022 Req dropped mid-transaction: the transaction SHALL complete and ack SHALL still pulse.
REQ-023 A req still high in the cycle after its ack SHALL be treated as a new request.

Reset
REQ-024 reset low SHALL immediately force IDLE, mem_en=0, mem_we=0, cpu_ack=0, dma_ack=0, rdata registers=0, counter=0, last-grant=DMA.
REQ-025 Reset mid-transaction SHALL abort without ack; no memory write may issue after reset asserts.

Configuration
REQ-026 Macro MEM_ARB_RR_EN defined: on simultaneous requests, grant the requester not served last (round-robin); last-grant updates at each ISSUE.
REQ-027 MEM_ARB_RR_EN undefined: CPU SHALL always win simultaneous requests; last-grant register SHALL be absent.

Structure
REQ-028 Shared package SHALL hold the FSM state encoding typedef (2-bit) and grant-ID constants GNT_CPU/GNT_DMA.
REQ-029 Winner selection SHALL be a sub-module arb_grant_sel (inputs cpu_req, dma_req, last_grant; output grant ID).

Verification
REQ-030 CPU read alone, MEM_LAT=1, addr 0x0000_0010, memory word 0x8C01_0004 -> mem_en pulse cycle 1, cpu_ack cycle 3, cpu_rdata=0x8C01_0004, cpu_stall high cycles 0-2.
REQ-031 DMA write addr 0x20 data 0xDEAD_BEEF, then CPU read 0x20 -> mem_we=1 only in ISSUE; CPU reads 0xDEAD_BEEF; dma_rdata unchanged.
REQ-032 Both req held continuously, RR enabled -> grants CPU, DMA, CPU, DMA; RR disabled -> CPU every transaction, DMA starved.
REQ-033 MEM_LAT=4 -> ack exactly 6 cycles after req; mem_en high exactly 1 cycle.
REQ-034 reset low during WAIT -> no ack, mem_en=0 immediately; after release, pending CPU req granted first.
REQ-035 cpu_req dropped during WAIT -> cpu_ack still pulses once in DONE.
